// File: rtl/icap_pkg.sv
// rtl/icap_pkg.sv - shared constants for the ICAP reboot sequencer
package icap_pkg;

  localparam logic [7:0] OPCODE_DEFAULT = 8'h0B;
  localparam logic [3:0] LAST_WORD      = 4'd11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [15:0] W_DUMMY   = 16'hFFFF;
  localparam logic [15:0] W_SYNC    = 16'hAA99;
  localparam logic [15:0] W_GEN1_WR = 16'h3261;
  localparam logic [15:0] W_GEN2_WR = 16'h3281;
  localparam logic [15:0] W_GEN3_WR = 16'h32A1;
  localparam logic [15:0] W_ZERO    = 16'h0000;
  localparam logic [15:0] W_CMD_WR  = 16'h30A1;
  localparam logic [15:0] W_IPROG   = 16'h000E;
  localparam logic [15:0] W_NOOP    = 16'h2000;

  // IPROG word sequence; words 3 and 5 carry the boot address and read opcode.
  function automatic logic [15:0] table_word(input logic [3:0] w,
                                             input logic [23:0] addr,
                                             input logic [7:0] opcode);
    logic [15:0] r;
    case (w)
      4'd0:    r = W_DUMMY;
      4'd1:    r = W_SYNC;
      4'd2:    r = W_GEN1_WR;
      4'd3:    r = addr[15:0];
      4'd4:    r = W_GEN2_WR;
      4'd5:    r = {opcode, addr[23:16]};
      4'd6:    r = W_GEN3_WR;
      4'd7:    r = W_ZERO;
      4'd8:    r = W_CMD_WR;
      4'd9:    r = W_IPROG;
      4'd10:   r = W_NOOP;
      4'd11:   r = W_NOOP;
      default: r = W_ZERO;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/icap_byte_wb_master.sv
// rtl/icap_byte_wb_master.sv - one Wishbone byte write to ICAP with ack watchdog
module icap_byte_wb_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [7:0]  byte_i,
  input  logic        ack_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        timeout_o
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [WDW-1:0] wdog_q, wdog_d;
  logic           expired;

  // Counter sits at zero outside a request, so every request starts fresh.
  assign expired   = (wdog_q == WDW'(TIMEOUT - 1));
  assign ack_o     = req_i & ack_i;
  assign timeout_o = req_i & ~ack_i & expired;

  assign cyc_o = req_i;
  assign stb_o = req_i;
  assign we_o  = req_i;
  assign dat_o = req_i ? {24'h000000, byte_i} : 32'h00000000;

  always_comb begin
    wdog_d = wdog_q;
    if (!req_i)
      wdog_d = '0;
    else if (!expired)
      wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wdog_q <= '0;
    else
      wdog_q <= wdog_d;
  end

endmodule

// File: rtl/icap_reboot_seq.sv
// rtl/icap_reboot_seq.sv - sequences the 24-byte IPROG reboot stream into ICAP
module icap_reboot_seq
  import icap_pkg::*;
#(
  parameter logic [7:0] OPCODE  = OPCODE_DEFAULT,
  parameter int         BITSWAP = 1,
  parameter int         TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [23:0] boot_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  input  logic        ack_i
);

  logic [2:0]  state_q, state_d;
  logic [3:0]  w_q, w_d;
  logic        h_q, h_d;
  logic [23:0] addr_q, addr_d;
  logic        error_q, error_d;

  logic [15:0] cur_word;
  logic [7:0]  cur_byte, tx_byte;
  logic        req, xfer_ack, xfer_timeout;

  assign cur_word = table_word(w_q, addr_q, OPCODE);
  assign cur_byte = h_q ? cur_word[15:8] : cur_word[7:0];
  assign tx_byte  = (BITSWAP != 0) ? bit_rev8(cur_byte) : cur_byte;

  assign req   = (state_q == ST_REQ);
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign error = error_q;

  icap_byte_wb_master #(
    .TIMEOUT(TIMEOUT)
  ) u_byte (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req),
    .byte_i   (tx_byte),
    .ack_i    (ack_i),
    .cyc_o    (cyc_o),
    .stb_o    (stb_o),
    .we_o     (we_o),
    .dat_o    (dat_o),
    .ack_o    (xfer_ack),
    .timeout_o(xfer_timeout)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    addr_d  = addr_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          addr_d  = boot_addr;
          error_d = 1'b0;
          w_d     = 4'd0;
          h_d     = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A late ack in the expiry cycle still counts as success.
        if (xfer_ack) begin
          state_d = ST_GAP;
        end else if (xfer_timeout) begin
          error_d = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_GAP: begin
        if (w_q == LAST_WORD && !h_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
          if (h_q) begin
            h_d = 1'b0;
          end else begin
            h_d = 1'b1;
            w_d = w_q + 4'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_q     <= 4'd0;
      h_q     <= 1'b0;
      addr_q  <= 24'h000000;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      addr_q  <= addr_d;
      error_q <= error_d;
    end
  end

endmodule

// File: doc/icap_reboot_seq.md
ICAP_REBOOT_SEQ -- requirements
Module: icap_reboot_seq

Interface
REQ-001 Parameter OPCODE, default 8'h0B, SPI flash read opcode placed in GENERAL2[15:8].
REQ-002 Parameter BITSWAP, default 1, reverses bit order within each byte before it is driven on dat_o.
REQ-003 Parameter TIMEOUT, default 255, is the maximum number of cycles to wait for ack_i per transfer.
REQ-004 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port go, input, 1: one-cycle start pulse, sampled only in IDLE.
REQ-007 Port boot_addr, input, 24: flash byte address of the image to boot, captured on an accepted go.
REQ-008 Port busy, output, 1: high in every state except IDLE.
REQ-009 Port done, output, 1: one-cycle pulse when the sequence completes.
REQ-010 Port error, output, 1: sticky ack-timeout flag, cleared by the next accepted go.
REQ-011 Ports cyc_o, stb_o, we_o, output, 1 each: Wishbone master strobes to the ICAP slave.
REQ-012 Port dat_o, output, 32: write data; bits [31:8] are always 0.
REQ-013 Port ack_i, input, 1: Wishbone acknowledge from the ICAP slave.

Function
REQ-014 The block SHALL implement FSM states IDLE, REQ, GAP, DONE and ERR.
REQ-015 On go in IDLE: capture boot_addr, clear error, clear word index w (0..11), byte select h=1 (high byte), go to REQ.
REQ-016 Word table: 0:FFFF, 1:AA99, 2:3261, 3:addr[15:0], 4:3281, 5:{OPCODE,addr[23:16]}, 6:32A1, 7:0000, 8:30A1, 9:000E, 10:2000, 11:2000.
REQ-017 Each word SHALL be sent as two byte writes, high byte first; 24 transfers in total.
REQ-018 In REQ, cyc_o=stb_o=we_o=1 and dat_o[7:0] holds the current byte, held stable until ack_i.
REQ-019 On ack_i in REQ, the FSM SHALL go to GAP; strobes drop for exactly one cycle.
REQ-020 On leaving GAP: advance h, then w; after byte 23, go to DONE, otherwise return to REQ.
REQ-021 In DONE, done=1 for one cycle, then return to IDLE.
REQ-022 A watchdog counter SHALL reset on entry to REQ and count while in REQ.
REQ-023 If the watchdog reaches TIMEOUT without ack_i, go to ERR: set error, drop strobes, return to IDLE next cycle; done is not pulsed.
REQ-024 If ack_i and the timeout occur in the same cycle, ack_i SHALL win.
REQ-025 go SHALL be ignored whenever busy=1.
REQ-026 ack_i SHALL be ignored outside REQ.
REQ-027 Per-byte cost: stb cycles until ack plus 1 GAP cycle; with a 3-cycle-ack slave, done is high 96 cycles after go.

Reset
REQ-028 Reset SHALL force state IDLE.
REQ-029 Reset SHALL clear busy, done, error, cyc_o, stb_o, we_o, dat_o, w, h, the watchdog and the captured address.
REQ-030 Reset asserted mid-sequence SHALL abort immediately with strobes low; no partial done is issued.

Structure
REQ-031 The word-table constants, state encodings and default OPCODE SHALL live in the shared package icap_pkg.
REQ-032 The bit-reversal and word/byte select SHALL be combinational, driven from the registered w and h.
REQ-033 A single sub-module, icap_byte_wb_master, SHALL perform one byte write with watchdog, returning ack or timeout.
REQ-034 The sequencer SHALL own only the table index and the top-level FSM.

Verification
REQ-035 go, boot_addr=24'h012345, BITSWAP=0, slave model acking in the 3rd stb cycle -> bytes FF FF AA 99 32 61 23 45 32 81 0B 01 32 A1 00 00 30 A1 00 0E 20 00 20 00; done pulses once.
REQ-036 Same as REQ-035 with BITSWAP=1 -> second word appears as bytes 55 99; byte 0x0B appears as D0.
REQ-037 Slave never acks, TIMEOUT=255 -> error=1 and stb_o=0 by cycle 257 after go; busy=0; done stays 0.
REQ-038 go pulsed again mid-sequence -> ignored; byte stream and timing identical to REQ-035.
REQ-039 Reset asserted during byte 10 -> strobes low immediately; a subsequent go restarts from FF FF.
REQ-040 ack_i in the same cycle the watchdog expires -> no error; sequence continues normally.
